// File: rtl/tile_map_arbiter.sv
// Two-port req/ack arbiter in front of the video tile-map memory port.
// Define FPGA_ROBOTS_TMARB_RR_EN for round-robin arbitration; default is fixed priority (A over B).
module tile_map_arbiter #(
  parameter int ADR_W  = 13,
  parameter int DAT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [ADR_W-1:0] a_adr,
  input  logic [DAT_W-1:0] a_wdat,
  output logic             a_ack,
  output logic [DAT_W-1:0] a_rdat,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [ADR_W-1:0] b_adr,
  input  logic [DAT_W-1:0] b_wdat,
  output logic             b_ack,
  output logic [DAT_W-1:0] b_rdat,
  output logic [ADR_W-1:0] tm_adr,
  output logic [DAT_W-1:0] tm_wrt,
  output logic             tm_wen,
  input  logic [DAT_W-1:0] tm_red,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

  state_t             state_q, state_d;
  logic               win_q, win_d;  // 0 = port A, 1 = port B
  logic               we_q, we_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [ADR_W-1:0]   tm_adr_q, tm_adr_d;
  logic [DAT_W-1:0]   tm_wrt_q, tm_wrt_d;
  logic               tm_wen_q, tm_wen_d;
  logic [DAT_W-1:0]   a_rdat_q, a_rdat_d;
  logic [DAT_W-1:0]   b_rdat_q, b_rdat_d;
  logic               gnt_b;

`ifdef FPGA_ROBOTS_TMARB_RR_EN
  logic last_q, last_d;  // last granted port; resets to B so A wins the first tie

  always_comb begin
    gnt_b = b_req & (~a_req | ~last_q);
  end
`else
  always_comb begin
    gnt_b = b_req & ~a_req;
  end
`endif

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    tm_adr_d = tm_adr_q;
    tm_wrt_d = tm_wrt_q;
    tm_wen_d = 1'b0;
    a_rdat_d = a_rdat_q;
    b_rdat_d = b_rdat_q;
`ifdef FPGA_ROBOTS_TMARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_d    = gnt_b;
          we_d     = gnt_b ? b_we : a_we;
          tm_adr_d = gnt_b ? b_adr : a_adr;
          tm_wrt_d = gnt_b ? b_wdat : a_wdat;
          tm_wen_d = gnt_b ? b_we : a_we;
`ifdef FPGA_ROBOTS_TMARB_RR_EN
          last_d   = gnt_b;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = ACK;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Memory data is stable by the last counted cycle; capture it then.
        if (cnt_q <= 2'd1) begin
          if (win_q) b_rdat_d = tm_red;
          else       a_rdat_d = tm_red;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      tm_adr_q <= '0;
      tm_wrt_q <= '0;
      tm_wen_q <= 1'b0;
      a_rdat_q <= '0;
      b_rdat_q <= '0;
`ifdef FPGA_ROBOTS_TMARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      tm_adr_q <= tm_adr_d;
      tm_wrt_q <= tm_wrt_d;
      tm_wen_q <= tm_wen_d;
      a_rdat_q <= a_rdat_d;
      b_rdat_q <= b_rdat_d;
`ifdef FPGA_ROBOTS_TMARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign a_ack  = (state_q == ACK) && !win_q;
  assign b_ack  = (state_q == ACK) &&  win_q;
  assign a_rdat = a_rdat_q;
  assign b_rdat = b_rdat_q;
  assign tm_adr = tm_adr_q;
  assign tm_wrt = tm_wrt_q;
  assign tm_wen = tm_wen_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Directed bench for tile_map_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3.
module tb_tile_map_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
  logic [12:0] a_adr, b_adr, tm_adr;
  logic [7:0]  a_wdat, b_wdat, a_rdat, b_rdat, tm_wrt, tm_red;
  logic        tm_wen, busy;

  logic        a3_req, a3_we, a3_ack, b3_req, b3_we, b3_ack;
  logic [12:0] a3_adr, b3_adr, tm3_adr;
  logic [7:0]  a3_wdat, b3_wdat, a3_rdat, b3_rdat, tm3_wrt, tm3_red;
  logic        tm3_wen, busy3;

  tile_map_arbiter #(.ADR_W(13), .DAT_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wdat(a_wdat), .a_ack(a_ack), .a_rdat(a_rdat),
    .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wdat(b_wdat), .b_ack(b_ack), .b_rdat(b_rdat),
    .tm_adr(tm_adr), .tm_wrt(tm_wrt), .tm_wen(tm_wen), .tm_red(tm_red), .busy(busy)
  );

  tile_map_arbiter #(.ADR_W(13), .DAT_W(8), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a3_req), .a_we(a3_we), .a_adr(a3_adr), .a_wdat(a3_wdat), .a_ack(a3_ack), .a_rdat(a3_rdat),
    .b_req(b3_req), .b_we(b3_we), .b_adr(b3_adr), .b_wdat(b3_wdat), .b_ack(b3_ack), .b_rdat(b3_rdat),
    .tm_adr(tm3_adr), .tm_wrt(tm3_wrt), .tm_wen(tm3_wen), .tm_red(tm3_red), .busy(busy3)
  );

  // Tile-map model: synchronous write, 1-cycle read for u_dut, 3-cycle read for u_dut3.
  logic [7:0] mem [0:8191];
  logic [7:0] rd1, r3_1, r3_2, r3_3;
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[13'h1FFF] <= 8'hC3;
      mem[13'h0042] <= 8'h3C;
    end else if (tm_wen) begin
      mem[tm_adr] <= tm_wrt;
    end
    rd1  <= mem[tm_adr];
    r3_1 <= mem[tm3_adr];
    r3_2 <= r3_1;
    r3_3 <= r3_2;
  end
  assign tm_red  = rd1;
  assign tm3_red = r3_3;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request at the current negedge, wait (bounded) for its ack, then drop req.
  task automatic xact(input bit pb, input bit we, input logic [12:0] adr, input logic [7:0] wd,
                      input int exp_n, input string tag, output logic [7:0] rd);
    int  n;
    int  wen_cnt;
    bit  found;
    n = 0; wen_cnt = 0; found = 0;
    if (pb) begin b_req = 1'b1; b_we = we; b_adr = adr; b_wdat = wd; end
    else    begin a_req = 1'b1; a_we = we; a_adr = adr; a_wdat = wd; end
    while (!found && n < 12) begin
      @(negedge clk);
      n++;
      if (tm_wen) wen_cnt++;
      if (n == 1) begin
        check({tag, "_tm_adr"}, 32'(tm_adr), 32'(adr));
        if (we) check({tag, "_tm_wrt"}, 32'(tm_wrt), 32'(wd));
      end
      if (pb ? b_ack : a_ack) found = 1;
    end
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_other_ack"}, 32'(pb ? a_ack : b_ack), 0);
    check({tag, "_wen_cycles"}, wen_cnt, we ? 1 : 0);
    rd = pb ? b_rdat : a_rdat;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, (a_ack | b_ack)}, 0);
  endtask

  logic [7:0] rd;
  int         k, cyc, acks, extra, i;
  bit         seq [0:4];
  bit         exp_seq [0:3];

  initial begin
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_adr = '0; a_wdat = '0;
    b_req = 0; b_we = 0; b_adr = '0; b_wdat = '0;
    a3_req = 0; a3_we = 0; a3_adr = '0; a3_wdat = '0;
    b3_req = 0; b3_we = 0; b3_adr = '0; b3_wdat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_tm_wen", 32'(tm_wen), 0);
    check("rst_acks", 32'({a_ack, b_ack}), 0);
    check("rst_rdat", 32'({a_rdat, b_rdat}), 0);
    check("rst_tm_adr", 32'(tm_adr), 0);
    check("rst_tm_wrt", 32'(tm_wrt), 0);
    rst_n = 1'b1;

    // Reset asserted while an A read sits in WAIT.
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_adr = 13'h0042;
    @(negedge clk);
    check("mid_issue_busy", 32'(busy), 1);
    @(negedge clk);
    check("mid_wait_noack", 32'(a_ack), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_wen", 32'(tm_wen), 0);
    check("mid_rst_ack", 32'({a_ack, b_ack}), 0);
    @(negedge clk);
    check("mid_rst_hold", 32'({busy, a_ack, b_ack}), 0);
    check("mid_rst_rdat", 32'(a_rdat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 0, 13'h0042, 8'h00, 3, "rec_rd", rd);
    check("rec_rd_data", 32'(rd), 32'h3C);

    xact(0, 1, 13'h0123, 8'h5A, 2, "a_wr", rd);
    check("a_wr_mem", 32'(mem[13'h0123]), 32'h5A);
    xact(0, 0, 13'h0123, 8'h00, 3, "a_rd", rd);
    check("a_rd_data", 32'(rd), 32'h5A);
    xact(1, 0, 13'h1FFF, 8'h00, 3, "b_rd1", rd);
    check("b_rd1_data", 32'(rd), 32'hC3);
    check("b_rd1_a_rdat_kept", 32'(a_rdat), 32'h5A);

    // RD_LAT=3 instance: B read ack on the 5th negedge after the request.
    b3_req = 1'b1; b3_we = 1'b0; b3_adr = 13'h1FFF;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("b_rd3_tm_wen", 32'(tm3_wen), 0);
    end while (!b3_ack && cyc < 12);
    check("b_rd3_lat", cyc, 5);
    check("b_rd3_data", 32'(b3_rdat), 32'hC3);
    check("b_rd3_a_rdat", 32'(a3_rdat), 0);
    check("b_rd3_a_ack", 32'(a3_ack), 0);
    check("b_rd3_tm_wrt", 32'(tm3_wrt), 0);
    b3_req = 1'b0;
    @(negedge clk);
    check("b_rd3_idle", 32'({busy3, b3_ack}), 0);

    // Both ports held for four transactions.
`ifdef FPGA_ROBOTS_TMARB_RR_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
    a_req = 1; a_we = 1; a_adr = 13'h0300; a_wdat = 8'h11;
    b_req = 1; b_we = 1; b_adr = 13'h0310; b_wdat = 8'h22;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_ack) begin seq[k] = 0; k++; a_adr = a_adr + 13'd1; end
      if (b_ack) begin seq[k] = 1; k++; b_adr = b_adr + 13'd1; end
    end
    a_req = 0; b_req = 0;
    check("arb_count", k, 4);
    for (int j = 0; j < 4; j++) check($sformatf("arb_grant%0d", j), 32'(seq[j]), 32'(exp_seq[j]));
    @(negedge clk);

    // A back-to-back: write/read pairs, req never dropped between transactions.
    a_req = 1; a_we = 1; a_adr = 13'h0200; a_wdat = 8'hA0;
    acks = 0; cyc = 0;
    while (acks < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      check("b2b_no_b_ack", 32'(b_ack), 0);
      if (a_ack) begin
        if (acks % 2 == 1) check($sformatf("b2b_rd%0d", acks), 32'(a_rdat), 32'(8'hA0 + 8'(acks / 2)));
        acks++;
        i = acks;
        a_we   = (i % 2 == 0);
        a_adr  = 13'h0200 + 13'(i / 2);
        a_wdat = 8'hA0 + 8'(i / 2);
        if (acks == 8) a_req = 0;
      end
    end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack || b_ack) extra++;
    end
    check("b2b_acks", acks, 8);
    check("b2b_extra", extra, 0);
    check("b2b_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tile_map_arbiter.md
# tile_map_arbiter

Shares the single tile-map memory port of the video generator (13-bit address, 8-bit data, synchronous read, write-enable strobe) between two requesters: port A (game-play engine) and port B (host/debug commands from the serial control path). It sits between those requesters and the video block's tile_map access port, serialising one access at a time with a req/ack handshake and returning read data.

## Interface
Parameters:
- ADR_W, 13, tile-map address width
- DAT_W, 8, tile-map data width
- RD_LAT, 1, tile-map read latency in cycles (legal 1..3), address-registered to data-valid

Ports:
- clk  in  1  system clock (~65 MHz pixel clock)
- rst_n  in  1  reset, asynchronous, active-low
- a_req  in  1  port A request; held with a_we/a_adr/a_wdat until a_ack
- a_we  in  1  port A: 1 = write, 0 = read
- a_adr  in  ADR_W  port A address
- a_wdat  in  DAT_W  port A write data
- a_ack  out  1  port A one-cycle completion pulse
- a_rdat  out  DAT_W  port A read data, valid while a_ack=1
- b_req, b_we, b_adr, b_wdat, b_ack, b_rdat  same as port A, for port B
- tm_adr  out  ADR_W  to video block tile-map address
- tm_wrt  out  DAT_W  to video block write data
- tm_wen  out  1  to video block write enable
- tm_red  in  DAT_W  from video block read data
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, ISSUE, WAIT, ACK. Reset: IDLE; all outputs 0 (a_ack, b_ack, a_rdat, b_rdat, tm_adr, tm_wrt, tm_wen, busy).
- IDLE: if any req high, pick winner (see Configuration), latch winner id; next state ISSUE, registering tm_adr, tm_wrt=winner wdat, tm_wen=winner we.
- ISSUE (one cycle): tm_* driven. Write → ACK. Read → WAIT, counter loaded RD_LAT.
- WAIT: counter decrements; on last cycle capture tm_red into winner's rdat; → ACK.
- ACK (one cycle): winner's ack=1; → IDLE. Loser's ack stays 0.
- tm_wen high only in ISSUE of a write; tm_adr/tm_wrt hold last value otherwise.
- xx_rdat holds last captured value until next read on that port; write does not change it.
- Requester drops req (or presents a new request) on the edge where it samples ack=1; req still high in IDLE is a new request.
- Requester changing adr/we/wdat before ack: undefined; bench does not exercise.

## Timing
- Request sampled at edge E0 (IDLE). tm_* valid after E0.
- Write: ack high after E0+1, for one cycle; back in IDLE after E0+2. Next grant earliest E0+2 sample.
- Read: ack and rdat valid after E0+1+RD_LAT; IDLE after E0+2+RD_LAT.
- Read latency counter 2 bits, no wrap for legal RD_LAT.
- rst_n low: immediate (asynchronous) return to IDLE, tm_wen=0, acks=0, mid-transaction request discarded (no ack issued). Deassertion synchronous to clk by upstream synchroniser.

## Configuration
- Macro FPGA_ROBOTS_TMARB_RR_EN.
- Defined: round-robin. One-bit last-winner register (reset = B, so A wins first tie). On simultaneous requests the port not granted last wins; single requester always wins.
- Undefined: fixed priority, A always beats B; B granted only when a_req=0 in IDLE. No last-winner register.

## Test plan
- Reset: rst_n low mid-read (state WAIT) → next cycle busy=0, tm_wen=0, no ack; after release, a fresh a_req read completes normally.
- A write adr=0x0123 wdat=0x5A → tm_adr=0x0123, tm_wrt=0x5A, tm_wen=1 for exactly one cycle; a_ack one cycle after; b_ack never.
- B read adr=0x1FFF, model returns 0xC3 with RD_LAT=1 and RD_LAT=3 → b_ack at E0+2 / E0+4, b_rdat=0xC3; a_rdat unchanged.
- a_req and b_req both held continuously for 4 transactions: with macro → grants A,B,A,B; without → A,A,A,A, b_ack never.
- Back-to-back: requester keeps req high after ack with new adr → second transaction starts at next IDLE sample, no dropped or duplicate acks (one ack per transaction, count=8 for 8 requests).
